// File: rtl/timebin_histogram_logger.sv
// N-channel time-bin histogrammer with ping-pong counter banks and a 16-bit readout framer.
// The active bank accumulates on sync_i while the frozen bank is streamed and read-cleared.
module timebin_histogram_logger #(
    parameter int          NCH       = 2,
    parameter int          NBINS     = 26,
    parameter int          CNT_W     = 16,
    parameter int          BYTE_SWAP = 1,
    parameter logic [15:0] HDR_WORD  = 16'hFEED,
    parameter logic [15:0] TRL_WORD  = 16'h0FED
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 clear_i,
    input  logic                 sync_i,
    input  logic [NCH*NBINS-1:0] photons_i,
    input  logic                 dump_i,
    output logic [15:0]          out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o,
    output logic                 overrun_o,
    output logic [NCH-1:0]       sat_o
);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BIN_W = (NBINS > 1) ? $clog2(NBINS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_CHAN, S_BIN, S_TRAIL} state_t;

    state_t           state;
    logic             bank_sel;
    logic [CNT_W-1:0] cnt [2][NCH][NBINS];
    logic [NCH-1:0]   sat [2];
    logic [CH_W-1:0]  ch_q;
    logic [BIN_W-1:0] bin_q;

    logic             frz;
    logic             accept;
    logic             last_bin;
    logic             last_ch;
    logic [CH_W-1:0]  ch_nxt;
    logic [BIN_W-1:0] bin_nxt;

    function automatic logic [15:0] count_word(input logic [CNT_W-1:0] c);
        logic [15:0] w;
        w = '0;
        w[CNT_W-1:0] = c;
        return (BYTE_SWAP != 0) ? {w[7:0], w[15:8]} : w;
    endfunction

    function automatic logic [15:0] chan_word(input logic s, input logic [CH_W-1:0] c);
        logic [7:0] c8;
        c8 = 8'(c);
        return {4'hC, s, 3'b000, c8};
    endfunction

    assign frz       = ~bank_sel;
    assign accept    = out_valid_o & out_ready_i;
    assign last_bin  = (bin_q == BIN_W'(NBINS - 1));
    assign last_ch   = (ch_q == CH_W'(NCH - 1));
    assign ch_nxt    = ch_q + CH_W'(1);
    assign bin_nxt   = bin_q + BIN_W'(1);
    assign overrun_o = dump_i & (state != S_IDLE) & ~clear_i;
    assign sat_o     = sat[bank_sel];

    // Counter banks: active bank accumulates, frozen bank is zeroed word by word as it is read out
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni || clear_i) begin
            for (int b = 0; b < 2; b++) begin
                sat[b] <= '0;
                for (int c = 0; c < NCH; c++)
                    for (int k = 0; k < NBINS; k++)
                        cnt[b][c][k] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < NBINS; k++)
                    if (sync_i && photons_i[c*NBINS+k]) begin
                        if (cnt[bank_sel][c][k] == CNT_MAX)
                            sat[bank_sel][c] <= 1'b1;
                        else
                            cnt[bank_sel][c][k] <= cnt[bank_sel][c][k] + CNT_W'(1);
                    end
            if (accept && state == S_BIN)
                cnt[frz][ch_q][bin_q] <= '0;
            if (accept && state == S_CHAN)
                sat[frz][ch_q] <= 1'b0;
        end
    end

    // Readout framer: next word is loaded into out_data_o as the current one is accepted
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= S_IDLE;
            bank_sel    <= 1'b0;
            ch_q        <= '0;
            bin_q       <= '0;
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else if (clear_i) begin
            state       <= S_IDLE;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (dump_i) begin
                    bank_sel    <= ~bank_sel;
                    state       <= S_HEADER;
                    out_data_o  <= HDR_WORD;
                    out_valid_o <= 1'b1;
                    busy_o      <= 1'b1;
                end
                S_HEADER: if (accept) begin
                    state      <= S_CHAN;
                    ch_q       <= '0;
                    out_data_o <= chan_word(sat[frz][0], '0);
                end
                S_CHAN: if (accept) begin
                    state      <= S_BIN;
                    bin_q      <= '0;
                    out_data_o <= count_word(cnt[frz][ch_q][0]);
                end
                S_BIN: if (accept) begin
                    if (!last_bin) begin
                        bin_q      <= bin_nxt;
                        out_data_o <= count_word(cnt[frz][ch_q][bin_nxt]);
                    end else if (!last_ch) begin
                        state      <= S_CHAN;
                        ch_q       <= ch_nxt;
                        out_data_o <= chan_word(sat[frz][ch_nxt], ch_nxt);
                    end else begin
                        state      <= S_TRAIL;
                        out_data_o <= TRL_WORD;
                    end
                end
                S_TRAIL: if (accept) begin
                    state       <= S_IDLE;
                    out_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timebin_histogram_logger.sv
// Bench for timebin_histogram_logger (NCH=2, NBINS=4, CNT_W=4): a behavioural model pushes
// expected frame words into a queue at each accepted dump; a monitor pops them on every handshake.
module tb_timebin_histogram_logger;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear_i, sync_i, dump_i, out_ready;
    logic [7:0]  photons;
    logic [15:0] out_data;
    logic        out_valid, busy, overrun;
    logic [1:0]  sat;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] q[$];
    int          mcnt[2][2][4];
    bit          msat[2][2];
    bit          mbank;
    bit          toggle_ready;
    bit          held_v;
    logic [15:0] held_d;

    timebin_histogram_logger #(
        .NCH(2), .NBINS(4), .CNT_W(4), .BYTE_SWAP(1),
        .HDR_WORD(16'hFEED), .TRL_WORD(16'h0FED)
    ) dut (
        .clk_i(clk), .reset_ni(reset_n), .clear_i(clear_i), .sync_i(sync_i),
        .photons_i(photons), .dump_i(dump_i), .out_data_o(out_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .busy_o(busy),
        .overrun_o(overrun), .sat_o(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare every accepted word, and hold-stability under backpressure
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (held_v) chk("stable", 32'(out_data), 32'(held_d));
            if (out_ready) begin
                if (q.size() == 0) chk("extra_word", 32'(q.size()), 32'd1);
                else               chk("word", 32'(out_data), 32'(q.pop_front()));
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held_d = out_data;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic model_zero();
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < 2; c++) begin
                msat[b][c] = 1'b0;
                for (int k = 0; k < 4; k++) mcnt[b][c][k] = 0;
            end
    endtask

    task automatic push_frame();
        logic [15:0] w;
        bit fb;
        fb = mbank;
        q.push_back(16'hFEED);
        for (int c = 0; c < 2; c++) begin
            q.push_back({4'hC, msat[fb][c], 3'b000, 8'(c)});
            msat[fb][c] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                w = 16'(mcnt[fb][c][k]);
                q.push_back({w[7:0], w[15:8]});
                mcnt[fb][c][k] = 0;
            end
        end
        q.push_back(16'h0FED);
        mbank = ~mbank;
    endtask

    // One clock: drive at posedge+1, check overrun at negedge, update model after the edge
    task automatic do_cycle(input bit s, input logic [7:0] ph, input bit d, input bit clr);
        bit was_busy;
        was_busy  = (q.size() != 0);
        sync_i    = s;
        photons   = ph;
        dump_i    = d;
        clear_i   = clr;
        out_ready = toggle_ready ? ~out_ready : 1'b1;
        @(negedge clk);
        if (d) chk("overrun", 32'(overrun), 32'(was_busy && !clr));
        @(posedge clk);
        #1;
        if (clr) begin
            model_zero();
            q.delete();
        end else begin
            if (s)
                for (int i = 0; i < 8; i++)
                    if (ph[i]) begin
                        if (mcnt[mbank][i/4][i%4] == 15) msat[mbank][i/4] = 1'b1;
                        else mcnt[mbank][i/4][i%4]++;
                    end
            if (d && !was_busy) push_frame();
        end
        sync_i = 1'b0; dump_i = 1'b0; clear_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("valid_after", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; clear_i = 1'b0; sync_i = 1'b0; dump_i = 1'b0;
        photons = '0; out_ready = 1'b1; toggle_ready = 1'b0; mbank = 1'b0;
        held_v = 1'b0; held_d = '0;
        model_zero();
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // 1: no dump -> nothing streamed
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
            chk("idle_valid", 32'(out_valid), 32'd0);
        end

        // 2: three syncs on ch0 bin1, dump, 12 words back-to-back
        repeat (3) do_cycle(1'b1, 8'h02, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("hdr_valid", 32'(out_valid), 32'd1);
        chk("hdr_busy", 32'(busy), 32'd1);
        chk("hdr_data", 32'(out_data), 32'h0000FEED);
        repeat (12) do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("gapless_left", 32'(q.size()), 32'd0);
        chk("gapless_busy", 32'(busy), 32'd0);

        // 3: saturation at CNT_W=4, then a second dump of a cleared bank
        repeat (20) do_cycle(1'b1, 8'h01, 1'b0, 1'b0);
        chk("sat_pre", 32'(sat), 32'd1);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("sat_swap", 32'(sat), 32'd0);
        chk("sat_q_ch0", 32'(q[1]), 32'h0000C800);
        chk("sat_q_bin0", 32'(q[2]), 32'h00000F00);
        drain(40);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("clr_q_ch0", 32'(q[1]), 32'h0000C000);
        chk("clr_q_bin0", 32'(q[2]), 32'h00000000);
        drain(40);

        // 4: ready toggling, sync coincident with dump lands in the frozen bank
        repeat (2) do_cycle(1'b1, 8'h90, 1'b0, 1'b0);
        toggle_ready = 1'b1;
        do_cycle(1'b1, 8'h80, 1'b1, 1'b0);
        drain(60);
        toggle_ready = 1'b0;

        // 5: syncs during readout count into the new active bank
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (5) do_cycle(1'b1, 8'h04, 1'b0, 1'b0);
        drain(40);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("acc_q_bin2", 32'(q[4]), 32'h00000500);
        drain(40);

        // 6: dump while busy -> overrun, then clear mid-frame
        repeat (2) do_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        drain(40);
        repeat (3) do_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (4) do_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        do_cycle(1'b1, 8'hFF, 1'b1, 1'b1);
        chk("clr_valid", 32'(out_valid), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_sat", 32'(sat), 32'd0);
        do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_clr_bin0", 32'(q[2]), 32'h00000000);
        drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
